// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic light subsystem: sensor conditioner
// FSM states, the controller's state encoding and default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_QUAL   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } sensor_state_t;

  // Light controller state encoding, kept here so both blocks share one package.
  typedef enum logic [1:0] {
    L_A_GREEN  = 2'd0,
    L_A_YELLOW = 2'd1,
    L_B_GREEN  = 2'd2,
    L_B_YELLOW = 2'd3
  } light_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_MAX_CYCLES      = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bundle: raw loop inputs and street-A green in, conditioned TA/TB out.
interface traffic_sensor_conditioner_if;
  logic sense_a_raw;
  logic sense_b_raw;
  logic GA;
  logic TA;
  logic TB;

  modport master (output sense_a_raw, sense_b_raw, GA, input TA, TB);
  modport slave  (input sense_a_raw, sense_b_raw, GA, output TA, TB);
endinterface

// File: rtl/sensor_debounce.sv
// One detector channel: 2-flop synchroniser, debounce qualification and
// hold-off stretch. Output is decoded from registered state only.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic active
);

  localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic          sync1;
  logic          s;
  sensor_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns both outputs; missing one infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (s) begin
          state_nxt = S_QUAL;
          cnt_nxt   = '0;
        end
      end
      S_QUAL: begin
        if (!s) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = S_ACTIVE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (!s) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        // A re-press cancels the hold-off without re-qualifying.
        if (s) begin
          state_nxt = S_ACTIVE;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign active = (state == S_ACTIVE) || (state == S_HOLD);

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Two conditioned detector channels feeding TA/TB. Define TRAFFIC_MAXGREEN_EN
// to add the max-green guard that masks TA so street B is not starved.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int MAX_CYCLES      = DEF_MAX_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_sensor_conditioner_if.slave  bus
);

  logic a_active;
  logic b_active;
  logic mask;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst),
    .raw   (bus.sense_a_raw),
    .active(a_active)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst),
    .raw   (bus.sense_b_raw),
    .active(b_active)
  );

`ifdef TRAFFIC_MAXGREEN_EN
  localparam int MW = $clog2(MAX_CYCLES + 1);
  localparam logic [MW-1:0] MG_LAST = MW'(MAX_CYCLES - 1);

  logic          qual;
  logic [MW-1:0] mg_cnt;

  assign qual = bus.GA & a_active & b_active;

  // mg_cnt saturates at its terminal value while masked so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mg_cnt <= '0;
      mask   <= 1'b0;
    end else begin
      if (!bus.GA) begin
        mask <= 1'b0;
      end else if (qual && (mg_cnt == MG_LAST)) begin
        mask <= 1'b1;
      end

      if (!qual) begin
        mg_cnt <= '0;
      end else if (mg_cnt != MG_LAST) begin
        mg_cnt <= mg_cnt + MW'(1);
      end
    end
  end
`else
  localparam int unused_max_cycles = MAX_CYCLES;
  logic unused_ga;
  assign unused_ga = bus.GA;
  assign mask      = 1'b0;
`endif

  assign bus.TA = a_active & ~mask;
  assign bus.TB = b_active;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner at default parameters; the
// max-green section adapts to whether TRAFFIC_MAXGREEN_EN is defined.
module tb_traffic_sensor_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  traffic_sensor_conditioner_if bus ();

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .MAX_CYCLES     (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, checking TA and TB after every one.
  task automatic run_expect(input string tag, input int n, input logic ta, input logic tb);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_ta"}, bus.TA, ta);
      check({tag, "_tb"}, bus.TB, tb);
    end
  endtask

  initial begin
    bus.sense_a_raw = 1'b1;
    bus.sense_b_raw = 1'b1;
    bus.GA          = 1'b0;

    // Reset held with both raw inputs high: outputs stay low.
    run_expect("in_reset", 5, 1'b0, 1'b0);

    // Release; edge 1 samples raw high, outputs rise on edge 7.
    rst = 1'b1;
    run_expect("rise_wait", 6, 1'b0, 1'b0);
    run_expect("rise_edge7", 1, 1'b1, 1'b1);

    // Both fall together: high for 10 edges, low on edge 11.
    bus.sense_a_raw = 1'b0;
    bus.sense_b_raw = 1'b0;
    run_expect("fall_wait", 10, 1'b1, 1'b1);
    run_expect("fall_edge11", 1, 1'b0, 1'b0);
    run_expect("idle", 4, 1'b0, 1'b0);

    // 3-cycle glitch on A is rejected.
    bus.sense_a_raw = 1'b1;
    tick(); tick(); tick();
    bus.sense_a_raw = 1'b0;
    run_expect("glitch", 15, 1'b0, 1'b0);

    // Clean press of 20 cycles then release.
    bus.sense_a_raw = 1'b1;
    run_expect("press_wait", 6, 1'b0, 1'b0);
    run_expect("press_high", 14, 1'b1, 1'b0);
    bus.sense_a_raw = 1'b0;
    run_expect("release_hold", 10, 1'b1, 1'b0);
    run_expect("release_edge11", 1, 1'b0, 1'b0);
    run_expect("release_idle", 3, 1'b0, 1'b0);

    // 5-cycle gap while active is bridged.
    bus.sense_a_raw = 1'b1;
    run_expect("gap5_wait", 6, 1'b0, 1'b0);
    run_expect("gap5_pre", 4, 1'b1, 1'b0);
    bus.sense_a_raw = 1'b0;
    run_expect("gap5_low", 5, 1'b1, 1'b0);
    bus.sense_a_raw = 1'b1;
    run_expect("gap5_after", 15, 1'b1, 1'b0);

    // 9-cycle gap exceeds the hold-off: TA drops on edge 11 after the fall.
    bus.sense_a_raw = 1'b0;
    run_expect("gap9_low", 9, 1'b1, 1'b0);
    bus.sense_a_raw = 1'b1;
    run_expect("gap9_hold", 1, 1'b1, 1'b0);
    run_expect("gap9_drop", 1, 1'b0, 1'b0);
    // Raw sampled high from edge 10: requalifies on edge 16.
    run_expect("gap9_requal_wait", 4, 1'b0, 1'b0);
    run_expect("gap9_requal", 1, 1'b1, 1'b0);

    // Bring B active as well, GA still low.
    bus.sense_b_raw = 1'b1;
    run_expect("b_wait", 6, 1'b1, 1'b0);
    run_expect("b_rise", 3, 1'b1, 1'b1);

    bus.GA = 1'b1;
`ifdef TRAFFIC_MAXGREEN_EN
    // 64 qualifying cycles, then TA is masked on edge 64.
    run_expect("mg_count", 63, 1'b1, 1'b1);
    run_expect("mg_mask", 1, 1'b0, 1'b1);
    run_expect("mg_masked", 6, 1'b0, 1'b1);
    bus.GA = 1'b0;
    run_expect("mg_release", 1, 1'b1, 1'b1);
    run_expect("mg_after", 3, 1'b1, 1'b1);
`else
    run_expect("no_mg", 80, 1'b1, 1'b1);
    bus.GA = 1'b0;
`endif

    // Drop both; A and B enter HOLD on edge 3, still high on edge 5.
    bus.sense_a_raw = 1'b0;
    bus.sense_b_raw = 1'b0;
    run_expect("hold_pre_reset", 5, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset_ta", bus.TA, 1'b0);
    check("async_reset_tb", bus.TB, 1'b0);
    run_expect("reset_held", 3, 1'b0, 1'b0);
    rst = 1'b1;
    run_expect("post_reset_idle", 20, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
